// File: rtl/seg_display_arbiter.sv
// Fixed-priority arbiter sharing one 4-digit 7-segment display between alarm/status/user sources,
// with a minimum on-screen hold time. Optional source-0 blinking is enabled by SEG_ARB_BLINK_EN.
module seg_display_arbiter #(
  parameter int TICK_DIV   = 50000000,
  parameter int HOLD_TICKS = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [19:0] data0,
  input  logic [19:0] data1,
  input  logic [19:0] data2,
  output logic [2:0]  gnt,
  output logic        busy,
  output logic [19:0] seg_data
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_TICKS);
  localparam logic [19:0]   BLANK    = 20'hFFFFF;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SHOW = 1'b1
  } state_t;

  // Lowest index wins: alarm beats status beats user.
  function automatic logic [2:0] pick_hp(input logic [2:0] r);
    logic [2:0] g;
    if (r[0]) begin
      g = 3'b001;
    end else if (r[1]) begin
      g = 3'b010;
    end else if (r[2]) begin
      g = 3'b100;
    end else begin
      g = 3'b000;
    end
    return g;
  endfunction

  function automatic logic [19:0] sel_data(input logic [2:0] g, input logic [19:0] d0,
                                           input logic [19:0] d1, input logic [19:0] d2);
    logic [19:0] d;
    case (g)
      3'b001:  d = d0;
      3'b010:  d = d1;
      3'b100:  d = d2;
      default: d = BLANK;
    endcase
    return d;
  endfunction

  state_t        r_state;
  logic [TW-1:0] r_tick_cnt;
  logic [HW-1:0] r_hold_cnt;
  logic [2:0]    r_gnt;
  logic          r_busy;
  logic [19:0]   r_data;

  state_t        w_state_nxt;
  logic [2:0]    w_gnt_nxt;
  logic [19:0]   w_data_nxt;
  logic          w_new_grant;
  logic          w_tick;
  logic          w_hold_met;
  logic          w_owner_req;
  logic [2:0]    w_hi_req;
  logic [2:0]    w_pick;

  assign w_tick      = (r_tick_cnt == TICK_MAX);
  assign w_hold_met  = (r_hold_cnt == HOLD_MAX);
  assign w_owner_req = |(req & r_gnt);
  // r_gnt - 1 turns the one-hot owner into a mask of every strictly higher-priority source.
  assign w_hi_req    = req & (r_gnt - 3'd1);
  assign w_pick      = pick_hp(req);

  // Free-running display tick; never realigned to grants.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tick_cnt <= {TW{1'b0}};
    end else if (w_tick) begin
      r_tick_cnt <= {TW{1'b0}};
    end else begin
      r_tick_cnt <= r_tick_cnt + {{(TW-1){1'b0}}, 1'b1};
    end
  end

  // Next owner, state and captured data.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_data_nxt  = r_data;
    w_new_grant = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req != 3'b000) begin
          w_state_nxt = ST_SHOW;
          w_gnt_nxt   = w_pick;
          w_data_nxt  = sel_data(w_pick, data0, data1, data2);
          w_new_grant = 1'b1;
        end else begin
          w_data_nxt  = BLANK;
        end
      end
      ST_SHOW: begin
        if (w_hold_met && ((w_hi_req != 3'b000) || (!w_owner_req && (req != 3'b000)))) begin
          w_gnt_nxt   = w_pick;
          w_data_nxt  = sel_data(w_pick, data0, data1, data2);
          w_new_grant = 1'b1;
        end else if (w_hold_met && !w_owner_req) begin
          w_state_nxt = ST_IDLE;
          w_gnt_nxt   = 3'b000;
          w_data_nxt  = BLANK;
        end else if (w_owner_req) begin
          w_data_nxt  = sel_data(r_gnt, data0, data1, data2);
        end else begin
          w_data_nxt  = r_data;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = 3'b000;
        w_data_nxt  = BLANK;
      end
    endcase
  end

  // Arbitration state and registered grant/busy/data.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_gnt   <= 3'b000;
      r_busy  <= 1'b0;
      r_data  <= BLANK;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_busy  <= (w_state_nxt == ST_SHOW);
      r_data  <= w_data_nxt;
    end
  end

  // Hold timer: a new grant's clear wins over a coincident tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold_cnt <= {HW{1'b0}};
    end else if (w_new_grant) begin
      r_hold_cnt <= {HW{1'b0}};
    end else if ((r_state == ST_SHOW) && w_tick && !w_hold_met) begin
      r_hold_cnt <= r_hold_cnt + {{(HW-1){1'b0}}, 1'b1};
    end else begin
      r_hold_cnt <= r_hold_cnt;
    end
  end

`ifdef SEG_ARB_BLINK_EN
  logic        r_blink;
  logic        w_blink_nxt;
  logic [19:0] r_seg_out;

  // Blink phase only advances while the alarm source keeps the display.
  always_comb begin
    w_blink_nxt = 1'b0;
    if (w_new_grant || (w_state_nxt != ST_SHOW) || (w_gnt_nxt != 3'b001)) begin
      w_blink_nxt = 1'b0;
    end else if (w_tick) begin
      w_blink_nxt = ~r_blink;
    end else begin
      w_blink_nxt = r_blink;
    end
  end

  // Blanked view of the captured data; r_data keeps the real codes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_blink   <= 1'b0;
      r_seg_out <= BLANK;
    end else begin
      r_blink   <= w_blink_nxt;
      r_seg_out <= w_blink_nxt ? BLANK : w_data_nxt;
    end
  end

  assign seg_data = r_seg_out;
`else
  assign seg_data = r_data;
`endif

  assign gnt  = r_gnt;
  assign busy = r_busy;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Scoreboard bench for seg_display_arbiter: a per-cycle reference model pushes expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_seg_display_arbiter;

  localparam int TD = 4;
  localparam int HT = 2;
  localparam logic [19:0] BLANK = 20'hFFFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  req = 3'b000;
  logic [19:0] data0 = 20'h00000;
  logic [19:0] data1 = 20'h00000;
  logic [19:0] data2 = 20'h00000;
  logic [2:0]  gnt;
  logic        busy;
  logic [19:0] seg_data;

  seg_display_arbiter #(.TICK_DIV(TD), .HOLD_TICKS(HT)) dut (
    .clk(clk), .reset(reset), .req(req),
    .data0(data0), .data1(data1), .data2(data2),
    .gnt(gnt), .busy(busy), .seg_data(seg_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  g;
    logic        b;
    logic [19:0] s;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  int          m_tick  = 0;
  int          m_owner = -1;
  int          m_hold  = 0;
  logic [19:0] m_shown = BLANK;
  bit          m_blink = 1'b0;

  function automatic int highest(input logic [2:0] r);
    for (int i = 0; i < 3; i++) begin
      if (r[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [19:0] src_data(input int i);
    if (i == 0) return data0;
    if (i == 1) return data1;
    return data2;
  endfunction

  // Reference: what the display shows after the coming clock edge.
  task automatic model_step(input logic rst, input logic [2:0] rq);
    bit tick_now;
    int top;
    if (rst) begin
      m_tick = 0; m_owner = -1; m_hold = 0; m_shown = BLANK; m_blink = 1'b0;
      return;
    end
    tick_now = (m_tick == TD - 1);
    m_tick   = (m_tick + 1) % TD;
    top      = highest(rq);
    if (m_owner < 0) begin
      if (top >= 0) begin
        m_owner = top; m_shown = src_data(top); m_hold = 0; m_blink = 1'b0;
      end
    end else if (m_hold == HT && top >= 0 && (top < m_owner || !rq[m_owner])) begin
      m_owner = top; m_shown = src_data(top); m_hold = 0; m_blink = 1'b0;
    end else if (m_hold == HT && !rq[m_owner]) begin
      m_owner = -1; m_shown = BLANK; m_blink = 1'b0;
    end else begin
      if (rq[m_owner]) m_shown = src_data(m_owner);
      if (tick_now && m_hold < HT) m_hold++;
`ifdef SEG_ARB_BLINK_EN
      if (m_owner == 0 && tick_now) m_blink = !m_blink;
`endif
    end
  endtask

  task automatic cyc(input logic rst, input logic [2:0] rq);
    exp_t e;
    reset = rst;
    req   = rq;
    model_step(rst, rq);
    e.g = (m_owner < 0) ? 3'b000 : (3'b001 << m_owner);
    e.b = (m_owner >= 0);
    e.s = (m_owner < 0 || m_blink) ? BLANK : m_shown;
    @(posedge clk);
    sb.push_back(e);
    #1;
  endtask

  task automatic run(input logic [2:0] rq, input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, rq);
  endtask

  // Monitor: the DUT presents a fresh output every cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (gnt !== e.g) begin
        errors++;
        $display("FAIL gnt t=%0t got=%b want=%b", $time, gnt, e.g);
      end
      checks++;
      if (busy !== e.b) begin
        errors++;
        $display("FAIL busy t=%0t got=%b want=%b", $time, busy, e.b);
      end
      checks++;
      if (seg_data !== e.s) begin
        errors++;
        $display("FAIL seg_data t=%0t got=%h want=%h", $time, seg_data, e.s);
      end
    end
  end

  initial begin
    logic [2:0] rq;
    cyc(1'b1, 3'b000);
    cyc(1'b1, 3'b000);
    run(3'b000, 20);

    // User message, released almost at once: held for the minimum time.
    data2 = 20'h00421;
    run(3'b100, 1);
    run(3'b000, 16);

    // Alarm arrives while user owns: taken over after the hold, no blank gap.
    run(3'b100, 3);
    data0 = 20'h5AD6B;
    run(3'b101, 16);
    run(3'b000, 14);

    // Continuous alarm starves status until it drops.
    data1 = 20'h12345;
    run(3'b001, 2);
    run(3'b011, 40);
    run(3'b010, 14);
    run(3'b000, 14);

    // Simultaneous status+user, status data tracked while owner.
    for (int i = 0; i < 10; i++) begin
      data1 = 20'($urandom);
      cyc(1'b0, 3'b110);
    end
    run(3'b000, 14);

    // Reset in the middle of a display.
    run(3'b100, 3);
    cyc(1'b1, 3'b100);
    run(3'b000, 4);

    // Long alarm ownership exercises the optional blink path.
    run(3'b001, 20);
    run(3'b000, 12);

    // Randomized traffic.
    rq = 3'b000;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) rq = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) data0 = 20'($urandom);
      if ($urandom_range(0, 7) == 0) data1 = 20'($urandom);
      if ($urandom_range(0, 7) == 0) data2 = 20'($urandom);
      cyc(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0, rq);
    end

    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_display_arbiter.md
Name: seg_display_arbiter

Overview:
- Shares the single 4-digit 7-segment display among three message sources: alarm, status and user.
- Drives the 20-bit character-code bus (4 digits × 5-bit codes, digit 3 in [19:15]) that feeds the display multiplexer.
- Uses fixed priority with a minimum on-screen hold time, so a message stays readable for a set period before another source takes the display.
- Sits between the game/control FSMs and the segment display controller.

Parameters:
- TICK_DIV, 50000000: clk cycles per display tick (1 s at 50 MHz); must be ≥1.
- HOLD_TICKS, 3: minimum ticks a granted message stays on screen; 0 means no minimum.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- req  input  3  request per source; bit 0 = alarm (highest priority), bit 2 = user (lowest)
- data0  input  20  4-digit character codes for source 0
- data1  input  20  4-digit character codes for source 1
- data2  input  20  4-digit character codes for source 2
- gnt  output  3  one-hot grant; 3'b000 when idle
- busy  output  1  high while any source owns the display
- seg_data  output  20  character codes to the display controller

Behaviour:
- Clock and reset: single clock domain; reset is synchronous and active-high, sampled on the posedge of clk.
- Reset values: gnt=0, busy=0, seg_data=20'hFFFFF (code 31 on every digit, i.e. blank), tick counter=0, hold_cnt=0, state=IDLE.
- Tick generator:
  - Counter runs 0..TICK_DIV-1 and wraps.
  - tick is high for one cycle when the counter equals TICK_DIV-1.
  - The counter free-runs in all states; it is not cleared on a grant.
- hold_cnt:
  - Width is $clog2(HOLD_TICKS+1), minimum 1 bit.
  - Cleared to 0 on every new grant.
  - Increments on tick while in SHOW and saturates at HOLD_TICKS.
  - hold_met = (hold_cnt == HOLD_TICKS).
- States:
  - IDLE: gnt=0, busy=0, seg_data=20'hFFFFF.
    - If req != 0, the next cycle enters SHOW with gnt = the highest-priority set bit.
    - On that same edge, seg_data loads that source's data and hold_cnt clears.
    - Grant latency is one cycle from a req sampled high.
  - SHOW: busy=1.
    - While the owner's req is high, seg_data re-registers the owner's data every cycle (1-cycle latency).
    - Once the owner's req drops, seg_data freezes at the last captured value.
- Re-arbitration in SHOW happens only when hold_met = 1. Evaluation uses registered hold_cnt, so the action occurs on the edge after hold_met becomes true.
  - A higher-priority req is set: switch directly to that source. gnt changes in one cycle with no blank gap; seg_data loads the new data; hold_cnt clears.
  - Otherwise, if the owner's req is low and another req is set: grant the highest pending source, with the same load/clear as above.
  - Otherwise, if the owner's req is low and no req is set: go to IDLE. seg_data returns to 20'hFFFFF on that edge.
  - Otherwise (the owner's req is still high): stay. Lower-priority requests never preempt, and starvation of lower sources under a continuous higher request is accepted.
- Owner drops req before hold_met: the display keeps the frozen data until hold_met, then applies the rules above.
- Owner re-asserts req before the release: it stays owner with no new grant and hold_cnt is not cleared.
- Simultaneous events: if the owner drops req and a higher source raises req in the same cycle, the highest pending source wins.
- tick coinciding with a grant edge: the clear takes precedence over the increment.
- Reset mid-SHOW: on the next edge, all outputs return to reset values regardless of req.

Optional Feature:
- Macro: SEG_ARB_BLINK_EN.
- When defined:
  - While source 0 owns the display, a blink flag toggles on every tick and clears on grant and on reset.
  - While the flag is 1, seg_data is driven as 20'hFFFFF; the captured data is retained internally and reappears when the flag returns to 0.
  - Sources 1 and 2 display steadily.
- When undefined: no blink logic; all sources display steadily.

Test Plan (TICK_DIV=4, HOLD_TICKS=2):
- Reset, then req=3'b000 for 20 cycles → gnt=0, busy=0, seg_data=20'hFFFFF throughout.
- req=3'b100 with data2=20'h0_0421 → one cycle later gnt=3'b100, busy=1, seg_data=20'h00421. Drop req after 1 cycle → seg_data holds 20'h00421 until 2 ticks elapse, then returns to 20'hFFFFF with gnt=0.
- Source 2 owns the display; at cycle 3 raise req[0] with data0=20'h5AD6B → source 2 is kept until hold_met, then gnt=3'b001 and seg_data=20'h5AD6B on the following edge, with no blank cycle in between.
- Source 0 owns the display; raise req[1] and keep req[0] high for 40 cycles → gnt stays 3'b001 and source 1 is never granted. Drop req[0] → after hold_met, gnt=3'b010.
- req=3'b110 asserted simultaneously from IDLE → gnt=3'b010. Change data1 while it is owner → seg_data follows with 1-cycle latency.
- Assert reset mid-SHOW → next edge gnt=0, busy=0, seg_data=20'hFFFFF. With SEG_ARB_BLINK_EN defined, source 0 owning → seg_data alternates data0 and 20'hFFFFF every 4 cycles.
